// File: rtl/fx_alu_pkg.sv
// fx_alu_pkg: shared opcode/state types, latency and range helpers for the fixed-point ALU.
package fx_alu_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_DIV, OP_SQRT} op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int div_lat(int n, int q);
        return n + q + 1;
    endfunction

    function automatic int sqrt_lat(int n, int q);
        return (n + q) / 2 + 1;
    endfunction

    function automatic longint fx_max(int n);
        return (longint'(1) <<< (n - 1)) - 1;
    endfunction

    function automatic longint fx_min(int n);
        return -(longint'(1) <<< (n - 1));
    endfunction
endpackage

// File: rtl/fx_alu_if.sv
// fx_alu_if: start/done request bus between a controller and the shared fixed-point ALU.
interface fx_alu_if
    import fx_alu_pkg::*;
#(parameter int N = 22);
    logic start;
    op_t op;
    logic signed [N-1:0] in_a;
    logic signed [N-1:0] in_b;
    logic busy;
    logic done;
    logic signed [N-1:0] result;
    logic overflow;
    logic dbz;
    logic neg_rad;
    modport master(output start, op, in_a, in_b, input busy, done, result, overflow, dbz, neg_rad);
    modport slave(input start, op, in_a, in_b, output busy, done, result, overflow, dbz, neg_rad);
endinterface

// File: rtl/fx_alu_sat.sv
// fx_sat: narrows a wide signed value to N bits, clamping or wrapping and flagging out-of-range.
module fx_sat
    import fx_alu_pkg::*;
#(
    parameter int W = 44,
    parameter int N = 22,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [W-1:0] d,
    output logic signed [N-1:0] q,
    output logic                ovf
);
    localparam logic signed [W-1:0] HI = W'(fx_max(N));
    localparam logic signed [W-1:0] LO = W'(fx_min(N));

    always_comb begin
        ovf = d > HI || d < LO;
        q = ovf && SATURATE ? (d[W-1] ? LO[N-1:0] : HI[N-1:0]) : d[N-1:0];
    end
endmodule

// File: rtl/fx_alu.sv
// fx_alu: time-shared fixed-point add/mul/div/sqrt unit behind one start/done handshake.
module fx_alu
    import fx_alu_pkg::*;
#(
    parameter int N = 22,
    parameter int Q = 10,
    parameter bit SATURATE = 1'b1
) (
    input logic       clk,
    input logic       rst,
    fx_alu_if.slave   bus
);
    localparam int XW = N + Q;
    localparam int RW = XW / 2;
    localparam int CW = $clog2(XW + 1);
    localparam logic signed [N-1:0] MAX = N'(fx_max(N));
    localparam logic signed [N-1:0] MIN = N'(fx_min(N));

    if ((XW % 2) != 0 || Q < 1 || Q >= N) begin : g_bad
        $error("fx_alu: N+Q must be even and 1 <= Q < N");
    end

    state_t st, st_nxt;
    op_t op_r;
    logic signed [N-1:0] a_r;
    logic [N-1:0] b_r, rem, rem_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [RW-1:0] root, root_nxt;
    logic [CW-1:0] cnt;
    logic neg, acc, zero_div, neg_sqrt, last, ge, bw;
    logic [N:0] sub_m, sub_s, diff;
    logic signed [2*N-1:0] prod, wide;
    logic signed [N-1:0] sat_q;
    logic sat_ovf;

    function automatic logic [N-1:0] mag(logic signed [N-1:0] v);
        return v[N-1] ? -v : v;
    endfunction

    assign acc = bus.start && st != RUN;
    assign zero_div = bus.op == OP_DIV && bus.in_b == '0;
    assign neg_sqrt = bus.op == OP_SQRT && bus.in_a[N-1];
    assign last = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else st <= st_nxt;
    end

    always_comb begin
        st_nxt = acc ? ((bus.op == OP_ADD || zero_div || neg_sqrt) ? DONE : RUN)
               : st == RUN ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        bus.busy = st == RUN;
        bus.done = st == DONE;
    end

    // DIV consumes one dividend bit per cycle, SQRT two radicand bits; both share this subtractor.
    always_comb begin
        sub_m = op_r == OP_DIV ? {rem, x[XW-1]} : {rem[N-2:0], x[XW-1 -: 2]};
        sub_s = op_r == OP_DIV ? {1'b0, b_r} : (N+1)'({root, 2'b01});
        {bw, diff} = {1'b0, sub_m} - {1'b0, sub_s};
        ge = !bw;
        rem_nxt = N'(ge ? diff : sub_m);
        x_nxt = op_r == OP_DIV ? {x[XW-2:0], ge} : {x[XW-3:0], 2'b00};
        root_nxt = {root[RW-2:0], ge};
        prod = (2*N)'(a_r) * (2*N)'($signed(b_r));
        wide = st != RUN ? (2*N)'(bus.in_a) + (2*N)'(bus.in_b)
             : op_r == OP_MUL ? prod >>> Q
             : neg ? -$signed((2*N)'(x_nxt)) : $signed((2*N)'(x_nxt));
    end

    fx_sat #(.W(2*N), .N(N), .SATURATE(SATURATE)) u_sat (.d(wide), .q(sat_q), .ovf(sat_ovf));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= OP_ADD;
            a_r <= '0;
            b_r <= '0;
            neg <= 1'b0;
            cnt <= '0;
            x <= '0;
            rem <= '0;
            root <= '0;
            bus.result <= '0;
            bus.overflow <= 1'b0;
            bus.dbz <= 1'b0;
            bus.neg_rad <= 1'b0;
        end else if (acc) begin
            op_r <= bus.op;
            a_r <= bus.in_a;
            b_r <= bus.op == OP_DIV ? mag(bus.in_b) : bus.in_b;
            neg <= bus.in_a[N-1] ^ bus.in_b[N-1];
            x <= {bus.op == OP_DIV ? mag(bus.in_a) : bus.in_a, {Q{1'b0}}};
            rem <= '0;
            root <= '0;
            cnt <= bus.op == OP_MUL ? CW'(1)
                 : bus.op == OP_DIV ? CW'(div_lat(N, Q) - 1) : CW'(sqrt_lat(N, Q) - 1);
            bus.overflow <= bus.op == OP_ADD && sat_ovf;
            bus.dbz <= zero_div;
            bus.neg_rad <= neg_sqrt;
            bus.result <= bus.op == OP_ADD ? sat_q
                        : zero_div ? (bus.in_a == '0 ? '0 : bus.in_a[N-1] ? MIN : MAX)
                        : neg_sqrt ? '0 : bus.result;
        end else if (st == RUN) begin
            cnt <= cnt - CW'(1);
            x <= x_nxt;
            rem <= rem_nxt;
            root <= root_nxt;
            if (last) begin
                bus.result <= op_r == OP_SQRT ? N'(root_nxt) : sat_q;
                bus.overflow <= op_r != OP_SQRT && sat_ovf;
            end
        end
    end
endmodule
